// File: rtl/sym_vn_pkg.sv
// Shared definitions for the symmetric 3-bit VN lookup-table datapath.
//   VN_DATA_W   : width of one quantised LUT entry
//   VN_PAGE_NUM : number of pages written per table load
//   VN_ADDR_W   : page address width
//   vn_ld_state_e : states of the LUT write-side loader
package sym_vn_pkg;

  localparam int VN_DATA_W   = 3;
  localparam int VN_PAGE_NUM = 32;
  localparam int VN_ADDR_W   = 5;

  typedef enum logic [1:0] {
    VN_LD_IDLE = 2'd0,
    VN_LD_LOAD = 2'd1,
    VN_LD_DONE = 2'd2
  } vn_ld_state_e;

endpackage

// File: rtl/sym_vn_lut_loader.sv
// Write-side sequencer for the symmetric VN lookup table.
// Accepts PAGE_NUM entries over a valid/ready handshake after load_start and
// writes each one, one cycle after acceptance, to both table replicates at
// the same page address.
// Ports:
//   write_clk, rst                 : clock, synchronous active-high reset
//   load_start                     : single-cycle request to start a load
//   lut_valid, lut_data, lut_ready : upstream entry handshake (page order)
//   lut_in_bank0_replicate_0/1     : write data, replicates 0 and 1
//   page_write_addr_replicate_0/1  : write page address, replicates 0 and 1
//   write_addr_offset_replicate_0/1: legacy offset, tied to 0
//   we                             : write enable for both replicates
//   busy                           : load in progress (LOAD or DONE)
//   load_done                      : one-cycle pulse with the last page write
module sym_vn_lut_loader
  import sym_vn_pkg::*;
#(
  parameter int PAGE_NUM = VN_PAGE_NUM,
  parameter int ADDR_W   = VN_ADDR_W,
  parameter int DATA_W   = VN_DATA_W
) (
  input  logic              write_clk,
  input  logic              rst,
  input  logic              load_start,
  input  logic              lut_valid,
  input  logic [DATA_W-1:0] lut_data,
  output logic              lut_ready,
  output logic [DATA_W-1:0] lut_in_bank0_replicate_0,
  output logic [ADDR_W-1:0] page_write_addr_replicate_0,
  output logic              write_addr_offset_replicate_0,
  output logic [DATA_W-1:0] lut_in_bank0_replicate_1,
  output logic [ADDR_W-1:0] page_write_addr_replicate_1,
  output logic              write_addr_offset_replicate_1,
  output logic              we,
  output logic              busy,
  output logic              load_done
);

  localparam logic [ADDR_W-1:0] LAST_PAGE = ADDR_W'(PAGE_NUM - 1);

  vn_ld_state_e      state_q, state_d;
  logic [ADDR_W-1:0] page_cnt_q, page_cnt_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              accept;

  assign lut_ready = (state_q == VN_LD_LOAD);
  assign accept    = lut_valid && lut_ready;

  always_comb begin
    state_d    = state_q;
    page_cnt_d = page_cnt_q;
    we_d       = 1'b0;
    data_d     = data_q;
    addr_d     = addr_q;
    case (state_q)
      VN_LD_IDLE: begin
        if (load_start) begin
          state_d    = VN_LD_LOAD;
          page_cnt_d = '0;
        end
      end
      VN_LD_LOAD: begin
        if (accept) begin
          we_d   = 1'b1;
          data_d = lut_data;
          addr_d = page_cnt_q;
          // Leave at the last page instead of incrementing, so the counter
          // never wraps and never issues an address beyond PAGE_NUM-1.
          if (page_cnt_q == LAST_PAGE) begin
            state_d = VN_LD_DONE;
          end else begin
            page_cnt_d = page_cnt_q + 1'b1;
          end
        end
      end
      VN_LD_DONE: begin
        state_d = VN_LD_IDLE;
      end
      default: begin
        state_d = VN_LD_IDLE;
      end
    endcase
  end

  // Data/address registers are reset too: after rst every output must read 0.
  always_ff @(posedge write_clk) begin
    if (rst) begin
      state_q    <= VN_LD_IDLE;
      page_cnt_q <= '0;
      we_q       <= 1'b0;
      data_q     <= '0;
      addr_q     <= '0;
    end else begin
      state_q    <= state_d;
      page_cnt_q <= page_cnt_d;
      we_q       <= we_d;
      data_q     <= data_d;
      addr_q     <= addr_d;
    end
  end

  // Both replicates are fed from the same registers so they can never diverge.
  assign lut_in_bank0_replicate_0      = data_q;
  assign lut_in_bank0_replicate_1      = data_q;
  assign page_write_addr_replicate_0   = addr_q;
  assign page_write_addr_replicate_1   = addr_q;
  assign write_addr_offset_replicate_0 = 1'b0;
  assign write_addr_offset_replicate_1 = 1'b0;
  assign we                            = we_q;
  assign busy                          = (state_q != VN_LD_IDLE);
  assign load_done                     = (state_q == VN_LD_DONE);

endmodule

// File: tb/tb_sym_vn_lut_loader.sv
// Self-checking bench for sym_vn_lut_loader: a directed vector table,
// multi-cycle load sequences and randomized traffic, all checked against a
// transaction-level reference model of the loader.
module tb_sym_vn_lut_loader;
  localparam int PN = 32;
  localparam int AW = 5;
  localparam int DW = 3;

  logic          write_clk = 1'b0;
  logic          rst = 1'b1;
  logic          load_start = 1'b0;
  logic          lut_valid = 1'b0;
  logic [DW-1:0] lut_data = '0;
  logic          lut_ready;
  logic [DW-1:0] d0, d1;
  logic [AW-1:0] a0, a1;
  logic          off0, off1, we, busy, load_done;

  always #5 write_clk = ~write_clk;

  sym_vn_lut_loader #(.PAGE_NUM(PN), .ADDR_W(AW), .DATA_W(DW)) dut (
    .write_clk(write_clk), .rst(rst), .load_start(load_start),
    .lut_valid(lut_valid), .lut_data(lut_data), .lut_ready(lut_ready),
    .lut_in_bank0_replicate_0(d0), .page_write_addr_replicate_0(a0),
    .write_addr_offset_replicate_0(off0),
    .lut_in_bank0_replicate_1(d1), .page_write_addr_replicate_1(a1),
    .write_addr_offset_replicate_1(off1),
    .we(we), .busy(busy), .load_done(load_done));

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: a load is "in progress" while fewer than PN pages have
  // been taken; one extra done cycle follows the last page.
  bit            m_loading = 0;
  bit            m_done = 0;
  int            m_taken = 0;
  logic          m_we = 0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_data = '0;

  int            we_cnt, done_cnt;
  logic [DW-1:0] mem0 [PN];
  logic [DW-1:0] mem1 [PN];
  logic [DW-1:0] pat  [PN];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    if (rst) begin
      m_loading = 0; m_done = 0; m_taken = 0;
      m_we = 0; m_addr = '0; m_data = '0;
    end else begin
      m_we = 0;
      if (m_done) begin
        m_done = 0;
      end else if (m_loading) begin
        if (lut_valid) begin
          m_we   = 1;
          m_addr = AW'(m_taken);
          m_data = lut_data;
          m_taken++;
          if (m_taken == PN) begin
            m_loading = 0;
            m_done    = 1;
          end
        end
      end else if (load_start) begin
        m_loading = 1;
        m_taken   = 0;
      end
    end
  endtask

  task automatic tick();
    @(posedge write_clk);
    model_edge();
    #1;
    chk("we", 32'(we), 32'(m_we));
    chk("lut_ready", 32'(lut_ready), 32'(m_loading));
    chk("busy", 32'(busy), 32'(m_loading || m_done));
    chk("load_done", 32'(load_done), 32'(m_done));
    chk("addr_rep0", 32'(a0), 32'(m_addr));
    chk("addr_rep1", 32'(a1), 32'(m_addr));
    chk("data_rep0", 32'(d0), 32'(m_data));
    chk("data_rep1", 32'(d1), 32'(m_data));
    chk("offsets", 32'({off1, off0}), 32'd0);
    if (we === 1'b1) begin
      we_cnt++;
      mem0[a0] = d0;
      mem1[a1] = d1;
    end
    if (load_done === 1'b1) begin
      done_cnt++;
      chk("done_with_last_write", 32'(we === 1'b1 && a0 == AW'(PN - 1)), 32'd1);
    end
  endtask

  // Full load with optional gaps (valid dropped every third cycle) and an
  // ignored load_start at page ign_page and optionally during DONE.
  task automatic run_load(input bit gaps, input int ign_page, input bit start_in_done);
    int i;
    int cyc;
    we_cnt = 0; done_cnt = 0;
    for (int k = 0; k < PN; k++) begin mem0[k] = '0; mem1[k] = '0; end
    load_start = 1; lut_valid = 0; tick();
    load_start = 0;
    i = 0; cyc = 0;
    while (i < PN && cyc < 300) begin
      lut_valid  = gaps ? (cyc % 3 != 2) : 1'b1;
      lut_data   = pat[i];
      load_start = (i == ign_page);
      tick();
      if (lut_valid) i++;
      cyc++;
    end
    chk("load_timeout", 32'(cyc < 300), 32'd1);
    lut_valid = 0; load_start = start_in_done;
    tick();
    load_start = 0;
    tick(); tick();
    chk("write_count", 32'(we_cnt), PN);
    chk("done_count", 32'(done_cnt), 32'd1);
    for (int k = 0; k < PN; k++) begin
      chk("mem_rep0", 32'(mem0[k]), 32'(pat[k]));
      chk("mem_rep1", 32'(mem1[k]), 32'(pat[k]));
    end
  endtask

  typedef struct {
    bit            rst, start, valid;
    logic [DW-1:0] data;
    bit            e_we;
    int            e_addr, e_data;
    bit            e_rdy, e_busy, e_done;
  } vec_t;

  vec_t vt [8];

  initial begin
    // rst, start, valid, data  -> we, addr, data, ready, busy, done
    vt[0] = '{1, 0, 0, 3'd0, 0, 0, 0, 0, 0, 0};
    vt[1] = '{0, 0, 1, 3'd6, 0, 0, 0, 0, 0, 0};  // valid ignored in idle
    vt[2] = '{0, 1, 0, 3'd0, 0, 0, 0, 1, 1, 0};  // start -> ready/busy
    vt[3] = '{0, 0, 1, 3'd5, 1, 0, 5, 1, 1, 0};  // page 0 written
    vt[4] = '{0, 0, 0, 3'd7, 0, 0, 5, 1, 1, 0};  // gap: outputs hold
    vt[5] = '{0, 1, 1, 3'd2, 1, 1, 2, 1, 1, 0};  // start ignored in load
    vt[6] = '{1, 1, 1, 3'd4, 0, 0, 0, 0, 0, 0};  // rst wins over start
    vt[7] = '{0, 0, 1, 3'd4, 0, 0, 0, 0, 0, 0};  // idle again

    rst = 1; tick(); tick();
    for (int v = 0; v < 8; v++) begin
      rst = vt[v].rst; load_start = vt[v].start;
      lut_valid = vt[v].valid; lut_data = vt[v].data;
      tick();
      chk("vec_we", 32'(we), 32'(vt[v].e_we));
      chk("vec_addr", 32'(a0), vt[v].e_addr);
      chk("vec_data", 32'(d1), vt[v].e_data);
      chk("vec_ready", 32'(lut_ready), 32'(vt[v].e_rdy));
      chk("vec_busy", 32'(busy), 32'(vt[v].e_busy));
      chk("vec_done", 32'(load_done), 32'(vt[v].e_done));
    end
    rst = 0; load_start = 0; lut_valid = 0;

    // Idle with valid held high: nothing happens.
    lut_valid = 1; we_cnt = 0;
    for (int k = 0; k < 10; k++) begin lut_data = DW'(k); tick(); end
    chk("idle_writes", 32'(we_cnt), 32'd0);
    lut_valid = 0;

    // Full load, no gaps, data i%8.
    for (int k = 0; k < PN; k++) pat[k] = DW'(k % 8);
    run_load(0, -1, 0);

    // Gapped load with random data.
    for (int k = 0; k < PN; k++) pat[k] = DW'($urandom_range(7));
    run_load(1, -1, 0);

    // Ignored starts at page 5 and during DONE.
    for (int k = 0; k < PN; k++) pat[k] = DW'(7 - (k % 8));
    run_load(0, 5, 1);

    // Reset at page 10, then a fresh load starting at address 0.
    load_start = 1; tick(); load_start = 0;
    for (int k = 0; k < 10; k++) begin lut_valid = 1; lut_data = DW'(k); tick(); end
    rst = 1; lut_data = 3'd3; tick();
    chk("rst_we", 32'(we), 32'd0);
    chk("rst_ready", 32'(lut_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 0; lut_valid = 0; tick();
    for (int k = 0; k < PN; k++) pat[k] = DW'($urandom_range(7));
    run_load(0, -1, 0);

    // Randomized traffic with occasional resets and starts.
    for (int k = 0; k < 1500; k++) begin
      rst        = ($urandom_range(99) == 0);
      load_start = ($urandom_range(7) == 0);
      lut_valid  = ($urandom_range(3) != 0);
      lut_data   = DW'($urandom_range(7));
      tick();
    end
    rst = 0; load_start = 0; lut_valid = 0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sym_vn_lut_loader.md
# sym_vn_lut_loader

Write-side sequencer for the symmetric 3-bit VN lookup table. It accepts a stream of LUT entries over a valid/ready handshake and drives the write ports of both table replicates in the VN rank, one page per accepted entry. The same entry goes to both replicates at the same time, so the two read ports always see identical contents. It sits between the IB-LUT update controller (upstream) and the `sym_vn_rank` write interface inside `sym_vn_lut_out`.

## Interface
Parameters:
- `PAGE_NUM`, 32: number of LUT pages per table load.
- `ADDR_W`, 5: page address width; must satisfy `2**ADDR_W >= PAGE_NUM`.
- `DATA_W`, 3: LUT entry width (quantised message).

Ports:
- `write_clk`  in  1  single clock for all logic (same clock as the rank write port).
- `rst`  in  1  synchronous, active-high reset.
- `load_start`  in  1  single-cycle request to begin a table load.
- `lut_valid`  in  1  upstream entry valid.
- `lut_data`  in  DATA_W  upstream entry, in page order 0..PAGE_NUM-1.
- `lut_ready`  out  1  loader accepts an entry this cycle.
- `lut_in_bank0_replicate_0`  out  DATA_W  write data, replicate 0.
- `page_write_addr_replicate_0`  out  ADDR_W  write address, replicate 0.
- `write_addr_offset_replicate_0`  out  1  deprecated; constant 0.
- `lut_in_bank0_replicate_1`  out  DATA_W  write data, replicate 1.
- `page_write_addr_replicate_1`  out  ADDR_W  write address, replicate 1.
- `write_addr_offset_replicate_1`  out  1  deprecated; constant 0.
- `we`  out  1  rank write enable.
- `busy`  out  1  high from the cycle after `load_start` is accepted until the cycle `load_done` is high, inclusive.
- `load_done`  out  1  one-cycle pulse after the last page is written.

## Operation
- FSM states: IDLE, LOAD, DONE.
- IDLE:
  - `lut_ready` = 0.
  - `load_start` = 1 → go to LOAD, clear `page_cnt` to 0.
  - `lut_valid` is ignored.
- LOAD:
  - `lut_ready` = 1.
  - An entry is accepted when `lut_valid && lut_ready`.
  - On acceptance: register `lut_data` into both replicate data outputs, register `page_cnt` into both address outputs, set `we`=1 for the next cycle.
  - After acceptance: `page_cnt` +1, unless `page_cnt == PAGE_NUM-1`, in which case go to DONE.
  - `lut_valid` = 0 → `we`=0 the next cycle, counter holds. Gaps of any length are legal.
- DONE:
  - `lut_ready` = 0, `load_done` = 1 for one cycle, then go to IDLE.
- `load_start` in LOAD or DONE is ignored; no restart and no error flag.
- When `we` = 0, the data and address outputs hold their last values.
- The two replicates always carry identical data, address and timing.
- `page_cnt` is ADDR_W bits wide. It never wraps, because the transition to DONE happens at PAGE_NUM-1. With PAGE_NUM < 2**ADDR_W, addresses ≥ PAGE_NUM are never issued.

## Timing
- Reset values (all outputs): `we`=0, `lut_ready`=0, `busy`=0, `load_done`=0, data=0, addresses=0, offsets=0. State = IDLE, `page_cnt`=0.
- `load_start` at cycle T → `lut_ready`=1 and `busy`=1 at T+1.
- Entry accepted at cycle T → `we`=1 with that entry's address and data at T+1. Fixed latency of 1 cycle.
- Last entry accepted at T:
  - `we`=1 (address PAGE_NUM-1) and `load_done`=1 at T+1.
  - `busy`=1 at T+1, 0 at T+2.
  - `lut_ready`=0 from T+1.
- Fastest full load: PAGE_NUM+2 cycles from `load_start` to return to IDLE.
- `rst` mid-load: next cycle returns to IDLE with all outputs at reset values. Any write in flight is dropped (`we` forced to 0). Pages already written are not rolled back.
- `rst` and `load_start` in the same cycle: `rst` wins.
- Back-to-back loads: `load_start` is honoured at the earliest in the cycle where state is IDLE again (T+2 after the last entry).

## Structure
- Shared package `sym_vn_pkg`: `VN_DATA_W`=3, `VN_PAGE_NUM`=32, `VN_ADDR_W`=5, and the FSM state enum (`VN_LD_IDLE`, `VN_LD_LOAD`, `VN_LD_DONE`).
- No sub-module required. The FSM, counter and output registers live in one module.
- The write-port signal names match the rank write interface exactly, so the loader connects port-to-port to `sym_vn_lut_out`.

## Test plan
- Reset then idle: hold `lut_valid`=1 with no `load_start` → `we`, `lut_ready`, `busy` stay 0; all outputs stay 0.
- Full load, no gaps: `load_start`, then entries `i%8` for pages 0..31 → `we`=1 for exactly 32 cycles, addr=i, data=i%8 on both replicates; `load_done` one pulse in the same cycle as the addr-31 write.
- Gapped load: drop `lut_valid` every third cycle → no `we` in gap cycles, addresses contiguous 0..31, `load_done` only after addr 31.
- `rst` at page 10: `we`=0 the next cycle, state IDLE; a fresh `load_start` restarts at addr 0.
- Ignored start: pulse `load_start` at page 5 and during DONE → counter unaffected, exactly 32 writes, single `load_done`.
- End-to-end with `sym_vn_lut_out`: load a known table, then read through ports A and B → both ports return the loaded entries (after I/O conversion) with the read-path latency.
